sd_cmd_framer: RTL and testbench

//  Builds a 48-bit SD SPI-mode command frame from a command index and a 32-bit argument.

---
 rtl/sd_spi_pkg.sv | 36 +++
 rtl/sd_crc7_serial.sv | 40 ++++
 rtl/sd_cmd_framer.sv | 168 ++++++++++++++++
 tb/tb_sd_cmd_framer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// ----------------------------------------------------------------------------
// sd_spi_pkg
//   Shared SD SPI-mode constants and types used by the command framer and
//   the CRC7 engine (also intended for the response/data-token checker).
//   Contents: frame start bits, CRC7 polynomial, frame length, stuff byte,
//   framer state enum, command struct and a one-bit CRC7 step function.
// ----------------------------------------------------------------------------
package sd_spi_pkg;

  localparam logic [1:0] SD_START       = 2'b01;
  localparam logic [6:0] CRC7_POLY      = 7'h09;  // x^7 + x^3 + 1, x^7 implicit
  localparam int         SD_FRAME_BYTES = 6;
  localparam logic [7:0] SD_STUFF       = 8'hFF;
  localparam int         SD_CMD_BITS    = 40;     // bits covered by CRC7

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_PRE,
    ST_SEND,
    ST_DONE
  } framer_state_e;

  // First 40 bits of a command frame, MSB first on the wire.
  typedef struct packed {
    logic [1:0]  start;
    logic [5:0]  index;
    logic [31:0] arg;
  } sd_cmd_t;

  // One MSB-first bit into the CRC7 LFSR.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    crc7_step = {crc[5:0], 1'b0} ^ ((b ^ crc[6]) ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// ----------------------------------------------------------------------------
// sd_crc7_serial
//   Bit-serial CRC7 (x^7+x^3+1), one bit per enabled cycle, MSB first.
//   Ports:
//     clk, rst_n   clock / async active-low reset
//     clr_i        zero the CRC (wins over en_i)
//     en_i         shift bit_i into the CRC this cycle
//     bit_i        serial data bit
//     crc_o        registered CRC
//     crc_nxt_o    CRC value after absorbing bit_i (combinational)
// ----------------------------------------------------------------------------
module sd_crc7_serial
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o,
  output logic [6:0] crc_nxt_o
);

  logic [6:0] crc_q, crc_d;

  assign crc_nxt_o = crc7_step(crc_q, bit_i);
  assign crc_o     = crc_q;

  always_comb begin
    crc_d = crc_q;
    if (clr_i)     crc_d = '0;
    else if (en_i) crc_d = crc_nxt_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end

endmodule

// File: rtl/sd_cmd_framer.sv
// ----------------------------------------------------------------------------
// sd_cmd_framer
//   Builds a 48-bit SD SPI-mode command frame and streams it byte-wise:
//   PRE_FF stuff bytes (0xFF), then {01,index}, arg[31:0] (4 bytes),
//   {crc7,1}. CRC7 is computed bit-serially in CALC (40 cycles) when CRC_EN.
//   Ports:
//     clk, rst_n                 clock / async active-low reset
//     cmd_valid_i/cmd_ready_o    command handshake (ready only in IDLE)
//     cmd_index_i, cmd_arg_i     command fields, sampled on accept
//     abort_i                    cancel current frame (ignored in IDLE)
//     tx_byte_o/tx_valid_o/tx_ready_i   byte stream to the SPI engine
//     busy_o                     not IDLE
//     done_o                     1-cycle pulse after last frame byte
//     crc7_o                     CRC7 of latest frame, held until next one
// ----------------------------------------------------------------------------
module sd_cmd_framer
  import sd_spi_pkg::*;
#(
  parameter int PRE_FF = 1,
  parameter bit CRC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  input  logic        abort_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [6:0]  crc7_o
);

  localparam logic [3:0] PRE_LAST  = (PRE_FF > 0) ? 4'(PRE_FF - 1) : 4'd0;
  localparam logic [5:0] CALC_LAST = 6'(SD_CMD_BITS - 1);
  localparam logic [2:0] BYTE_LAST = 3'(SD_FRAME_BYTES - 1);
  localparam framer_state_e ST_AFTER_CALC   = (PRE_FF > 0) ? ST_PRE : ST_SEND;
  localparam framer_state_e ST_AFTER_ACCEPT = CRC_EN ? ST_CALC : ST_AFTER_CALC;

  framer_state_e state_q, state_d;
  logic [39:0]   sr_q, sr_d;
  logic [5:0]    calc_cnt_q, calc_cnt_d;
  logic [3:0]    pre_cnt_q, pre_cnt_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [6:0]    crc7_q, crc7_d;
  logic [6:0]    crc_w, crc_nxt;
  logic [7:0]    frame_byte;
  sd_cmd_t       cmd_in;
  logic          accept, xfer, calc_last, pre_last, byte_last;

  assign cmd_in    = '{start: SD_START, index: cmd_index_i, arg: cmd_arg_i};
  assign accept    = (state_q == ST_IDLE) && cmd_valid_i;
  assign xfer      = tx_valid_o && tx_ready_i;
  assign calc_last = (calc_cnt_q == CALC_LAST);
  assign pre_last  = (pre_cnt_q == PRE_LAST);
  assign byte_last = (byte_cnt_q == BYTE_LAST);
  assign crc7_o    = crc7_q;

  // The shift register rotates rather than shifts, so after 40 CALC cycles
  // it holds the original command again and the byte mux can read it.
  sd_crc7_serial u_crc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (accept),
    .en_i      (state_q == ST_CALC),
    .bit_i     (sr_q[39]),
    .crc_o     (crc_w),
    .crc_nxt_o (crc_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid_i)          state_d = ST_AFTER_ACCEPT;
        ST_CALC: if (calc_last)            state_d = ST_AFTER_CALC;
        ST_PRE:  if (xfer && pre_last)     state_d = ST_SEND;
        ST_SEND: if (xfer && byte_last)    state_d = ST_DONE;
        ST_DONE:                           state_d = ST_IDLE;
        default:                           state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next-state: shift register, counters, published CRC
  always_comb begin
    sr_d       = sr_q;
    calc_cnt_d = calc_cnt_q;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    crc7_d     = crc7_q;
    if (accept) begin
      sr_d       = cmd_in;
      calc_cnt_d = '0;
      pre_cnt_d  = '0;
      byte_cnt_d = '0;
    end else begin
      case (state_q)
        ST_CALC: begin
          sr_d = {sr_q[38:0], sr_q[39]};
          if (!calc_last)    calc_cnt_d = calc_cnt_q + 6'd1;
          else if (!abort_i) crc7_d     = crc_nxt;  // includes the 40th bit
        end
        ST_PRE:  if (xfer && !pre_last)  pre_cnt_d  = pre_cnt_q + 4'd1;
        ST_SEND: if (xfer && !byte_last) byte_cnt_d = byte_cnt_q + 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= '0;
      calc_cnt_q <= '0;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      crc7_q     <= '0;
    end else begin
      sr_q       <= sr_d;
      calc_cnt_q <= calc_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc7_q     <= crc7_d;
    end
  end

  // Frame byte mux
  always_comb begin
    case (byte_cnt_q)
      3'd0:    frame_byte = sr_q[39:32];
      3'd1:    frame_byte = sr_q[31:24];
      3'd2:    frame_byte = sr_q[23:16];
      3'd3:    frame_byte = sr_q[15:8];
      3'd4:    frame_byte = sr_q[7:0];
      default: frame_byte = CRC_EN ? {crc_w, 1'b1} : SD_STUFF;
    endcase
  end

  // Outputs are decoded from registered state only, so tx_byte_o holds
  // steady through stalls.
  always_comb begin
    cmd_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    tx_valid_o  = 1'b0;
    tx_byte_o   = 8'h00;
    case (state_q)
      ST_IDLE: begin cmd_ready_o = 1'b1; busy_o = 1'b0; end
      ST_PRE:  begin tx_valid_o = 1'b1; tx_byte_o = SD_STUFF;   end
      ST_SEND: begin tx_valid_o = 1'b1; tx_byte_o = frame_byte; end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// ----------------------------------------------------------------------------
// tb_sd_cmd_framer
//   Two framer builds side by side: u_dut (CRC_EN=1, PRE_FF=1) and
//   u_dut_nc (CRC_EN=0, PRE_FF=1). Expected frames come from a polynomial
//   long-division CRC7 and byte-level frame assembly.
// ----------------------------------------------------------------------------
module tb_sd_cmd_framer;

  localparam int TB_PRE = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_valid_nc, abort, tx_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  logic        cmd_ready, tx_valid, busy, done;
  logic [7:0]  tx_byte;
  logic [6:0]  crc7;
  logic        cmd_ready_nc, tx_valid_nc, busy_nc, done_nc;
  logic [7:0]  tx_byte_nc;
  logic [6:0]  crc7_nc;

  always #5 clk = ~clk;

  sd_cmd_framer #(.PRE_FF(TB_PRE), .CRC_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_index_i(cmd_index), .cmd_arg_i(cmd_arg), .abort_i(abort),
    .tx_byte_o(tx_byte), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .busy_o(busy), .done_o(done), .crc7_o(crc7)
  );

  sd_cmd_framer #(.PRE_FF(TB_PRE), .CRC_EN(1'b0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid_nc), .cmd_ready_o(cmd_ready_nc),
    .cmd_index_i(cmd_index), .cmd_arg_i(cmd_arg), .abort_i(1'b0),
    .tx_byte_o(tx_byte_nc), .tx_valid_o(tx_valid_nc), .tx_ready_i(tx_ready),
    .busy_o(busy_nc), .done_o(done_nc), .crc7_o(crc7_nc)
  );

  int tests = 0, fails = 0;
  logic [127:0] got_v, exp_v;
  int got_n, exp_n, done_cnt, done_cyc, end_cyc, first_x, last_x, stall_err;

  // Remainder of M(x)*x^7 divided by x^7+x^3+1 (0x89), by long division.
  function automatic logic [6:0] ref_crc7(input logic [5:0] idx, input logic [31:0] arg);
    logic [46:0] r;
    r = {2'b01, idx, arg, 7'h00};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic mk_exp(input logic [5:0] idx, input logic [31:0] arg, input bit crc_en);
    logic [7:0] fr [6];
    fr[0] = {2'b01, idx};
    fr[1] = arg[31:24];
    fr[2] = arg[23:16];
    fr[3] = arg[15:8];
    fr[4] = arg[7:0];
    fr[5] = crc_en ? {ref_crc7(idx, arg), 1'b1} : 8'hFF;
    exp_v = '0; exp_n = 0;
    for (int i = 0; i < TB_PRE; i++) begin exp_v = {exp_v[119:0], 8'hFF}; exp_n++; end
    for (int i = 0; i < 6; i++)      begin exp_v = {exp_v[119:0], fr[i]}; exp_n++; end
  endtask

  // Starts at a negedge; issues one command and collects the byte stream
  // until the framer is idle again. Leaves the bench at a negedge.
  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input int pct,
                          input bit nc, input bit ab);
    logic pv, pr, v, rdy_o, dn;
    logic [7:0] pb, b;
    int cyc;
    got_v = '0; got_n = 0; done_cnt = 0; done_cyc = -1; end_cyc = -1;
    first_x = -1; last_x = -1; stall_err = 0;
    cmd_index = idx; cmd_arg = arg; abort = ab; tx_ready = 1'b0;
    if (nc) cmd_valid_nc = 1'b1; else cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_valid_nc = 1'b0; abort = 1'b0;
    cmd_index = 6'($urandom); cmd_arg = $urandom;  // must not affect the frame
    pv = 1'b0; pr = 1'b0; pb = 8'h00; rdy_o = 1'b0;
    for (cyc = 1; cyc <= 3000; cyc++) begin
      if (cyc > 1) @(negedge clk);
      tx_ready = ($urandom_range(0, 99) < pct);
      v     = nc ? tx_valid_nc  : tx_valid;
      b     = nc ? tx_byte_nc   : tx_byte;
      dn    = nc ? done_nc      : done;
      rdy_o = nc ? cmd_ready_nc : cmd_ready;
      if (pv && !pr && (!v || b !== pb)) stall_err++;
      if (v && tx_ready) begin
        got_v = {got_v[119:0], b}; got_n++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      if (dn) begin done_cnt++; done_cyc = cyc; end
      if (rdy_o) begin end_cyc = cyc; break; end
      pv = v; pr = tx_ready; pb = b;
    end
    tests++;
    if (!rdy_o) begin
      fails++;
      $display("FAIL send_timeout cmd%0d: framer not idle after 3000 cycles", idx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cmd_valid = 0; cmd_valid_nc = 0; abort = 0; tx_ready = 0;
    cmd_index = '0; cmd_arg = '0;
    #2 rst_n = 1'b0;
    #10;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    tests++; if (tx_valid !== 1'b0)  begin fails++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL rst_done got=%b exp=0", done); end
    tests++; if (tx_byte !== 8'h00)  begin fails++; $display("FAIL rst_tx_byte got=%h exp=00", tx_byte); end
    tests++; if (crc7 !== 7'h00)     begin fails++; $display("FAIL rst_crc7 got=%h exp=00", crc7); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cmd0();
    send_cmd(6'd0, 32'h0, 100, 1'b0, 1'b0);
    mk_exp(6'd0, 32'h0, 1'b1);
    tests++; if (got_v !== 128'hFF_40_00_00_00_00_95 || got_n != 7) begin
      fails++; $display("FAIL cmd0_bytes got=%h n=%0d exp=ff40000000000095 n=7", got_v, got_n); end
    tests++; if (got_v !== exp_v || got_n != exp_n) begin
      fails++; $display("FAIL cmd0_model got=%h exp=%h", got_v, exp_v); end
    tests++; if (crc7 !== 7'h4A) begin fails++; $display("FAIL cmd0_crc7 got=%h exp=4a", crc7); end
    tests++; if (done_cnt != 1)  begin fails++; $display("FAIL cmd0_done_count got=%0d exp=1", done_cnt); end
    tests++; if (done_cyc != 48) begin fails++; $display("FAIL cmd0_latency got=%0d exp=48", done_cyc); end
    tests++; if (end_cyc != 49)  begin fails++; $display("FAIL cmd0_ready_after_done got=%0d exp=49", end_cyc); end
  endtask

  task automatic test_cmd8();
    send_cmd(6'd8, 32'h0000_01AA, 100, 1'b0, 1'b0);
    tests++; if (got_v !== 128'hFF_48_00_00_01_AA_87 || got_n != 7) begin
      fails++; $display("FAIL cmd8_bytes got=%h n=%0d exp=ff48000001aa87 n=7", got_v, got_n); end
    tests++; if (crc7 !== 7'h43) begin fails++; $display("FAIL cmd8_crc7 got=%h exp=43", crc7); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] v55;
    send_cmd(6'd55, 32'h0, 100, 1'b0, 1'b0);
    v55 = got_v;
    tests++; if (v55 !== 128'hFF_77_00_00_00_00_65) begin
      fails++; $display("FAIL cmd55_bytes got=%h exp=ff770000000065", v55); end
    send_cmd(6'd41, 32'h4000_0000, 100, 1'b0, 1'b0);
    mk_exp(6'd41, 32'h4000_0000, 1'b1);
    tests++; if (got_v !== 128'hFF_69_40_00_00_00_77 || got_v !== exp_v) begin
      fails++; $display("FAIL acmd41_bytes got=%h exp=ff694000000077", got_v); end
    tests++; if (last_x - first_x != 6) begin
      fails++; $display("FAIL acmd41_no_bubble got span=%0d exp=6", last_x - first_x); end
    tests++; if (first_x != 41) begin
      fails++; $display("FAIL acmd41_first_byte got cycle=%0d exp=41", first_x); end
  endtask

  task automatic test_random_stall();
    logic [5:0] idx; logic [31:0] arg;
    for (int k = 0; k < 6; k++) begin
      idx = 6'($urandom); arg = $urandom;
      send_cmd(idx, arg, 30, 1'b0, 1'b0);
      mk_exp(idx, arg, 1'b1);
      tests++; if (got_v !== exp_v || got_n != exp_n) begin
        fails++; $display("FAIL stall_frame[%0d] got=%h n=%0d exp=%h n=%0d", k, got_v, got_n, exp_v, exp_n); end
      tests++; if (stall_err != 0) begin
        fails++; $display("FAIL stall_hold[%0d] got %0d unstable stalls exp=0", k, stall_err); end
      tests++; if (done_cnt != 1) begin
        fails++; $display("FAIL stall_done[%0d] got=%0d exp=1", k, done_cnt); end
      tests++; if (crc7 !== ref_crc7(idx, arg)) begin
        fails++; $display("FAIL stall_crc7[%0d] got=%h exp=%h", k, crc7, ref_crc7(idx, arg)); end
    end
  endtask

  task automatic test_abort();
    int nx, dn; bit hit;
    cmd_index = 6'd0; cmd_arg = 32'h0; cmd_valid = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    nx = 0; hit = 1'b0;
    // walk until frame byte 3 (5th offered byte incl. the stuff byte) is on offer
    for (int c = 0; c < 200 && !hit; c++) begin
      if (tx_valid && nx == TB_PRE + 3) begin
        hit = 1'b1; abort = 1'b1; tx_ready = 1'b0;
      end else begin
        tx_ready = 1'b1;
        if (tx_valid) nx++;
        @(negedge clk);
      end
    end
    tests++; if (!hit) begin fails++; $display("FAIL abort_reach_byte3 got offered=%0d exp=%0d", nx, TB_PRE + 3); end
    @(negedge clk);
    abort = 1'b0;
    tests++; if (tx_valid !== 1'b0)  begin fails++; $display("FAIL abort_tx_valid got=%b exp=0", tx_valid); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL abort_cmd_ready got=%b exp=1", cmd_ready); end
    tests++; if (crc7 !== 7'h4A)     begin fails++; $display("FAIL abort_crc7_held got=%h exp=4a", crc7); end
    dn = (done === 1'b1) ? 1 : 0;
    repeat (5) begin @(negedge clk); if (done === 1'b1) dn++; end
    tests++; if (dn != 0) begin fails++; $display("FAIL abort_no_done got=%0d pulses exp=0", dn); end
    // abort high together with cmd_valid in IDLE: command still accepted
    send_cmd(6'd0, 32'h0, 100, 1'b0, 1'b1);
    tests++; if (got_v !== 128'hFF_40_00_00_00_00_95 || done_cnt != 1) begin
      fails++; $display("FAIL abort_next_cmd0 got=%h done=%0d exp=ff40000000000095 done=1", got_v, done_cnt); end
  endtask

  task automatic test_reset_mid_calc();
    cmd_index = 6'd0; cmd_arg = 32'h0; cmd_valid = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL calc_busy got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL async_rst_state got busy=%b ready=%b exp busy=0 ready=1", busy, cmd_ready); end
    tests++; if (crc7 !== 7'h00 || tx_valid !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL async_rst_outputs got crc7=%h valid=%b done=%b exp 00/0/0", crc7, tx_valid, done); end
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(6'd17, 32'h0, 100, 1'b1, 1'b0);
    mk_exp(6'd17, 32'h0, 1'b0);
    tests++; if (got_v !== 128'hFF_51_00_00_00_00_FF || got_v !== exp_v) begin
      fails++; $display("FAIL nocrc_cmd17 got=%h exp=ff5100000000ff", got_v); end
    tests++; if (first_x != 1) begin fails++; $display("FAIL nocrc_skip_calc got first=%0d exp=1", first_x); end
    tests++; if (done_cnt != 1 || crc7_nc !== 7'h00) begin
      fails++; $display("FAIL nocrc_done_crc got done=%0d crc7=%h exp 1/00", done_cnt, crc7_nc); end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_back_to_back();
    test_random_stall();
    test_abort();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
